// File: rtl/storage_exc_ctrl_pkg.sv
// Shared types and constants for the storage exception controller:
// state encoding, SPR bit positions, default vectors and small helpers.
package storage_exc_ctrl_pkg;

  // 32-bit architectural word, bit 0 is the most significant bit
  typedef logic [0:31] word_t;

  // Exception sequencing states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FLUSH    = 3'd1,
    ST_SAVE     = 3'd2,
    ST_MSRUPD   = 3'd3,
    ST_REDIRECT = 3'd4
  } exc_state_e;

  // MSR bits cleared on exception entry, and the ESR store indicator
  localparam logic [4:0] MSR_EE = 5'd16;
  localparam logic [4:0] MSR_PR = 5'd17;
  localparam logic [4:0] ESR_ST = 5'd8;

  // Default interrupt vectors
  localparam word_t DSI_VEC_DEF = 32'h0000_0300;
  localparam word_t ISI_VEC_DEF = 32'h0000_0400;

  // Complete registered output set of the controller
  typedef struct packed {
    logic  busy;
    logic  flush;
    logic  srr0_we;
    word_t srr0_wd;
    logic  srr1_we;
    word_t srr1_wd;
    logic  dear_we;
    word_t dear_wd;
    logic  esr_we;
    word_t esr_wd;
    logic  msr_we;
    word_t msr_wd;
    logic  pc_redirect;
    word_t npc;
    logic  dsi_ack;
    logic  isi_ack;
  } exc_out_t;

  // MSR value written on exception entry: problem state and external
  // interrupts are disabled, every other bit is preserved
  function automatic word_t msr_on_entry(input word_t msr_cap);
    word_t m;
    m         = msr_cap;
    m[MSR_PR] = 1'b0;
    m[MSR_EE] = 1'b0;
    return m;
  endfunction

  // ESR value for a data storage interrupt: only the store indicator
  function automatic word_t esr_for_dsi(input logic is_store);
    word_t e;
    e         = 32'h0000_0000;
    e[ESR_ST] = is_store;
    return e;
  endfunction

endpackage

// File: rtl/storage_exc_ctrl_if.sv
// Bundle between the DSI/ISI request latches, the pipeline and the
// SPR/MSR/PC update logic. slave = the exception controller view,
// master = the surrounding logic view.
interface storage_exc_ctrl_if;
  import storage_exc_ctrl_pkg::*;

  // requests from the sticky latches and pipeline status
  logic  dsi;
  logic  isi;
  word_t dsi_pc;
  word_t dsi_ea;
  logic  dsi_isStore;
  word_t isi_pc;
  word_t MSR;
  logic  pipe_drained;

  // controller results
  logic  dsi_ack;
  logic  isi_ack;
  logic  busy;
  logic  flush;
  logic  srr0_we;
  word_t srr0_wd;
  logic  srr1_we;
  word_t srr1_wd;
  logic  dear_we;
  word_t dear_wd;
  logic  esr_we;
  word_t esr_wd;
  logic  msr_we;
  word_t msr_wd;
  logic  pc_redirect;
  word_t npc;

  modport slave (
    input  dsi, isi, dsi_pc, dsi_ea, dsi_isStore, isi_pc, MSR, pipe_drained,
    output dsi_ack, isi_ack, busy, flush,
    output srr0_we, srr0_wd, srr1_we, srr1_wd, dear_we, dear_wd,
    output esr_we, esr_wd, msr_we, msr_wd, pc_redirect, npc
  );

  modport master (
    output dsi, isi, dsi_pc, dsi_ea, dsi_isStore, isi_pc, MSR, pipe_drained,
    input  dsi_ack, isi_ack, busy, flush,
    input  srr0_we, srr0_wd, srr1_we, srr1_wd, dear_we, dear_wd,
    input  esr_we, esr_wd, msr_we, msr_wd, pc_redirect, npc
  );

endinterface

// File: rtl/storage_exc_ctrl.sv
// Storage exception controller: accepts a pending DSI/ISI (DSI first, it is
// the older instruction), flushes the pipeline, saves SRR0/SRR1 (plus
// DEAR/ESR for DSI), updates MSR, redirects fetch to the vector and acks
// the request latches. All outputs are registered and decoded from the
// state being entered, so each strobe lines up with its state cycle.
module storage_exc_ctrl
  import storage_exc_ctrl_pkg::*;
#(
  parameter word_t DSI_VEC = DSI_VEC_DEF,
  parameter word_t ISI_VEC = ISI_VEC_DEF
) (
  input  logic                clk,
  input  logic                rst,
  storage_exc_ctrl_if.slave   bus
);

  exc_state_e state_r;
  exc_state_e state_nxt_s;
  logic       accept_s;

  logic       sel_dsi_r;
  word_t      cap_pc_r;
  word_t      cap_ea_r;
  logic       cap_st_r;
  word_t      cap_msr_r;

  exc_out_t   out_r;
  exc_out_t   out_nxt_s;

  // Next-state logic; acceptance happens only from IDLE
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.dsi | bus.isi) begin
          state_nxt_s = ST_FLUSH;
          accept_s    = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (bus.pipe_drained) begin
          state_nxt_s = ST_SAVE;
        end else begin
          state_nxt_s = ST_FLUSH;
        end
      end
      ST_SAVE:     state_nxt_s = ST_MSRUPD;
      ST_MSRUPD:   state_nxt_s = ST_REDIRECT;
      ST_REDIRECT: state_nxt_s = ST_IDLE;
      default:     state_nxt_s = ST_IDLE;
    endcase
  end

  // Output decode for the state about to be entered (Moore, registered below)
  always_comb begin
    out_nxt_s = '0;
    case (state_nxt_s)
      ST_IDLE: begin
        out_nxt_s.busy = 1'b0;
      end
      ST_FLUSH: begin
        out_nxt_s.busy  = 1'b1;
        out_nxt_s.flush = 1'b1;
      end
      ST_SAVE: begin
        out_nxt_s.busy    = 1'b1;
        out_nxt_s.srr0_we = 1'b1;
        out_nxt_s.srr0_wd = cap_pc_r;
        out_nxt_s.srr1_we = 1'b1;
        out_nxt_s.srr1_wd = cap_msr_r;
        if (sel_dsi_r) begin
          out_nxt_s.dear_we = 1'b1;
          out_nxt_s.dear_wd = cap_ea_r;
          out_nxt_s.esr_we  = 1'b1;
          out_nxt_s.esr_wd  = esr_for_dsi(cap_st_r);
        end else begin
          out_nxt_s.dear_we = 1'b0;
          out_nxt_s.esr_we  = 1'b0;
        end
      end
      ST_MSRUPD: begin
        out_nxt_s.busy   = 1'b1;
        out_nxt_s.msr_we = 1'b1;
        out_nxt_s.msr_wd = msr_on_entry(cap_msr_r);
      end
      ST_REDIRECT: begin
        out_nxt_s.busy        = 1'b1;
        out_nxt_s.pc_redirect = 1'b1;
        out_nxt_s.npc         = sel_dsi_r ? DSI_VEC : ISI_VEC;
        out_nxt_s.dsi_ack     = sel_dsi_r;
        // a pending ISI is either the one serviced or a fetch just flushed
        out_nxt_s.isi_ack     = 1'b1;
      end
      default: begin
        out_nxt_s = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      out_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      out_r   <= out_nxt_s;
    end
  end

  // Capture the faulting context once, in the accept cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_dsi_r <= 1'b0;
      cap_pc_r  <= 32'h0000_0000;
      cap_ea_r  <= 32'h0000_0000;
      cap_st_r  <= 1'b0;
      cap_msr_r <= 32'h0000_0000;
    end else if (accept_s) begin
      sel_dsi_r <= bus.dsi;
      cap_pc_r  <= bus.dsi ? bus.dsi_pc : bus.isi_pc;
      cap_ea_r  <= bus.dsi_ea;
      cap_st_r  <= bus.dsi & bus.dsi_isStore;
      cap_msr_r <= bus.MSR;
    end else begin
      sel_dsi_r <= sel_dsi_r;
      cap_pc_r  <= cap_pc_r;
      cap_ea_r  <= cap_ea_r;
      cap_st_r  <= cap_st_r;
      cap_msr_r <= cap_msr_r;
    end
  end

  assign bus.busy        = out_r.busy;
  assign bus.flush       = out_r.flush;
  assign bus.srr0_we     = out_r.srr0_we;
  assign bus.srr0_wd     = out_r.srr0_wd;
  assign bus.srr1_we     = out_r.srr1_we;
  assign bus.srr1_wd     = out_r.srr1_wd;
  assign bus.dear_we     = out_r.dear_we;
  assign bus.dear_wd     = out_r.dear_wd;
  assign bus.esr_we      = out_r.esr_we;
  assign bus.esr_wd      = out_r.esr_wd;
  assign bus.msr_we      = out_r.msr_we;
  assign bus.msr_wd      = out_r.msr_wd;
  assign bus.pc_redirect = out_r.pc_redirect;
  assign bus.npc         = out_r.npc;
  assign bus.dsi_ack     = out_r.dsi_ack;
  assign bus.isi_ack     = out_r.isi_ack;

endmodule

// File: tb/tb_storage_exc_ctrl.sv
// Bench for storage_exc_ctrl: directed scenarios with literal expectations,
// then random request/drain/reset traffic, all checked every cycle against
// a transaction-level model of the exception sequence.
module tb_storage_exc_ctrl;

  logic clk;
  logic rst;

  storage_exc_ctrl_if bus ();

  storage_exc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // MSR[16]=EE and MSR[17]=PR in MSB-first numbering; ESR[8]=ST
  localparam logic [31:0] PR_EE_MASK = 32'h0000_C000;
  localparam logic [31:0] ESR_ST_VAL = 32'h0080_0000;

  // model: one outstanding exception and how far it has progressed
  bit          m_busy;
  int          m_phase;   // 0 flushing, 1 save, 2 msr update, 3 redirect
  bit          m_sel, m_st;
  logic [31:0] m_pc, m_ea, m_msr;
  bit          m_dsi_ack, m_isi_ack;

  // architectural effect as seen from DUT writes and from the model
  logic [31:0] dut_srr0, dut_srr1, dut_dear, dut_esr, dut_msr, dut_npc;
  logic [31:0] mdl_srr0, mdl_msr, mdl_esr;
  int n_redir, n_dsi_ack, n_isi_ack, n_dear_we, n_esr_we, n_flush;

  bit lat_dsi, lat_isi;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // compare process: advance the model with what the DUT just sampled
  always @(posedge clk) begin
    bit sv, mu, rd;
    logic [31:0] e_str, g_str;
    #1;
    if (rst) begin
      m_busy  = 1'b0;
      m_phase = 0;
    end else if (!m_busy) begin
      if (bus.dsi || bus.isi) begin
        m_busy  = 1'b1;
        m_phase = 0;
        m_sel   = bus.dsi;
        m_pc    = bus.dsi ? bus.dsi_pc : bus.isi_pc;
        m_ea    = bus.dsi_ea;
        m_st    = bus.dsi_isStore;
        m_msr   = bus.MSR;
      end
    end else if (m_phase == 0) begin
      if (bus.pipe_drained) m_phase = 1;
    end else if (m_phase == 3) begin
      m_busy  = 1'b0;
      m_phase = 0;
    end else begin
      m_phase = m_phase + 1;
    end

    sv = m_busy && (m_phase == 1);
    mu = m_busy && (m_phase == 2);
    rd = m_busy && (m_phase == 3);
    m_dsi_ack = rd && m_sel;
    m_isi_ack = rd;

    e_str = {22'd0, m_busy, m_busy && (m_phase == 0), sv, sv, sv && m_sel, sv && m_sel,
             mu, rd, rd && m_sel, rd};
    g_str = {22'd0, bus.busy, bus.flush, bus.srr0_we, bus.srr1_we, bus.dear_we, bus.esr_we,
             bus.msr_we, bus.pc_redirect, bus.dsi_ack, bus.isi_ack};
    chk("strobes", g_str, e_str);
    if (sv) begin
      chk("srr0_wd", bus.srr0_wd, m_pc);
      chk("srr1_wd", bus.srr1_wd, m_msr);
      mdl_srr0 = m_pc;
    end
    if (sv && m_sel) begin
      chk("dear_wd", bus.dear_wd, m_ea);
      chk("esr_wd", bus.esr_wd, m_st ? ESR_ST_VAL : 32'h0000_0000);
      mdl_esr = m_st ? ESR_ST_VAL : 32'h0000_0000;
    end
    if (mu) begin
      chk("msr_wd", bus.msr_wd, m_msr & ~PR_EE_MASK);
      mdl_msr = m_msr & ~PR_EE_MASK;
    end
    if (rd) chk("npc", bus.npc, m_sel ? 32'h0000_0300 : 32'h0000_0400);
    if (rst) chk("reset_data", bus.srr0_wd | bus.srr1_wd | bus.dear_wd | bus.esr_wd |
                               bus.msr_wd | bus.npc, 32'h0000_0000);

    if (bus.srr0_we) dut_srr0 = bus.srr0_wd;
    if (bus.srr1_we) dut_srr1 = bus.srr1_wd;
    if (bus.dear_we) begin dut_dear = bus.dear_wd; n_dear_we++; end
    if (bus.esr_we) begin dut_esr = bus.esr_wd; n_esr_we++; end
    if (bus.msr_we) dut_msr = bus.msr_wd;
    if (bus.pc_redirect) begin dut_npc = bus.npc; n_redir++; end
    if (bus.dsi_ack) n_dsi_ack++;
    if (bus.isi_ack) n_isi_ack++;
    if (bus.flush) n_flush++;
  end

  // one cycle of the request latches: an ack clears its latch
  task automatic cyc();
    @(negedge clk);
    if (m_dsi_ack) lat_dsi = 1'b0;
    if (m_isi_ack) lat_isi = 1'b0;
    bus.dsi = lat_dsi;
    bus.isi = lat_isi;
  endtask

  task automatic set_dsi(input logic [31:0] pc, input logic [31:0] ea, input bit st);
    lat_dsi         = 1'b1;
    bus.dsi         = 1'b1;
    bus.dsi_pc      = pc;
    bus.dsi_ea      = ea;
    bus.dsi_isStore = st;
  endtask

  task automatic set_isi(input logic [31:0] pc);
    lat_isi    = 1'b1;
    bus.isi    = 1'b1;
    bus.isi_pc = pc;
  endtask

  task automatic wait_redirect(output int n);
    n = 0;
    while (!bus.pc_redirect && n < 40) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((m_busy || lat_dsi || lat_isi) && n < budget) begin
      cyc();
      n++;
    end
    checks++;
    if (m_busy || lat_dsi || lat_isi) begin
      errors++;
      $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic clear_shadows();
    dut_srr0 = 32'hDEAD_BEEF; dut_srr1 = 32'hDEAD_BEEF; dut_dear = 32'hDEAD_BEEF;
    dut_esr  = 32'hDEAD_BEEF; dut_msr  = 32'hDEAD_BEEF; dut_npc  = 32'hDEAD_BEEF;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, r0, a0, i0, f0, d0, e0;
    rst = 1'b1;
    bus.dsi = 1'b0; bus.isi = 1'b0; bus.dsi_pc = 32'h0; bus.dsi_ea = 32'h0;
    bus.dsi_isStore = 1'b0; bus.isi_pc = 32'h0; bus.MSR = 32'h0; bus.pipe_drained = 1'b1;
    lat_dsi = 1'b0; lat_isi = 1'b0;
    repeat (3) cyc();
    chk("reset_busy", bus.busy, 32'd0);
    chk("reset_npc", bus.npc, 32'd0);
    rst = 1'b0;
    cyc();

    // DSI load
    clear_shadows();
    bus.MSR = 32'h0002_C030;
    set_dsi(32'h0000_0100, 32'h0000_1234, 1'b0);
    cyc();
    bus.MSR = 32'hFFFF_FFFF;
    bus.dsi_ea = 32'h0BAD_0BAD;
    n = 1;
    begin int k; wait_redirect(k); n = n + k; end
    chk("dsi_load_latency", n, 32'd4);
    chk("dsi_load_dsi_ack", bus.dsi_ack, 32'd1);
    chk("dsi_load_isi_ack", bus.isi_ack, 32'd1);
    wait_idle(20);
    chk("dsi_load_srr0", dut_srr0, 32'h0000_0100);
    chk("dsi_load_srr1", dut_srr1, 32'h0002_C030);
    chk("dsi_load_dear", dut_dear, 32'h0000_1234);
    chk("dsi_load_esr", dut_esr, 32'h0000_0000);
    chk("dsi_load_msr", dut_msr, 32'h0002_0030);
    chk("dsi_load_npc", dut_npc, 32'h0000_0300);
    chk("model_srr0", mdl_srr0, 32'h0000_0100);
    chk("model_msr", mdl_msr, 32'h0002_0030);

    // DSI store
    clear_shadows();
    cyc();
    set_dsi(32'h0000_0104, 32'h0000_5678, 1'b1);
    wait_idle(20);
    chk("dsi_store_esr", dut_esr, 32'h0080_0000);
    chk("model_esr", mdl_esr, 32'h0080_0000);
    chk("dsi_store_dear", dut_dear, 32'h0000_5678);

    // ISI alone
    clear_shadows();
    d0 = n_dear_we; e0 = n_esr_we;
    cyc();
    set_isi(32'h0000_2000);
    begin int k; wait_redirect(k); end
    chk("isi_dsi_ack", bus.dsi_ack, 32'd0);
    chk("isi_isi_ack", bus.isi_ack, 32'd1);
    chk("isi_npc", bus.npc, 32'h0000_0400);
    wait_idle(20);
    chk("isi_srr0", dut_srr0, 32'h0000_2000);
    chk("isi_no_dear", n_dear_we - d0, 32'd0);
    chk("isi_no_esr", n_esr_we - e0, 32'd0);

    // both in the same cycle: one DSI sequence cancels the ISI
    clear_shadows();
    r0 = n_redir; a0 = n_dsi_ack; i0 = n_isi_ack;
    cyc();
    set_dsi(32'h0000_0180, 32'h0000_0ABC, 1'b0);
    set_isi(32'h0000_2400);
    wait_idle(20);
    repeat (5) cyc();
    chk("both_sequences", n_redir - r0, 32'd1);
    chk("both_srr0", dut_srr0, 32'h0000_0180);
    chk("both_npc", dut_npc, 32'h0000_0300);
    chk("both_dsi_acks", n_dsi_ack - a0, 32'd1);
    chk("both_isi_acks", n_isi_ack - i0, 32'd1);

    // drain wait: five cycles undrained keep flush up for six
    f0 = n_flush;
    cyc();
    bus.pipe_drained = 1'b0;
    set_dsi(32'h0000_0140, 32'h0000_0010, 1'b0);
    repeat (5) cyc();
    cyc();
    bus.pipe_drained = 1'b1;
    wait_idle(20);
    chk("drain_flush_cycles", n_flush - f0, 32'd6);

    // reset during MSRUPD aborts; the still-set latch is serviced afterwards
    a0 = n_dsi_ack;
    cyc();
    set_dsi(32'h0000_0200, 32'h0000_0020, 1'b1);
    n = 0;
    while (!bus.msr_we && n < 20) begin cyc(); n++; end
    chk("rst_reached_msrupd", bus.msr_we, 32'd1);
    rst = 1'b1;
    cyc();
    chk("rst_abort_busy", bus.busy, 32'd0);
    chk("rst_abort_no_ack", n_dsi_ack - a0, 32'd0);
    rst = 1'b0;
    wait_idle(20);
    chk("rst_restart_ack", n_dsi_ack - a0, 32'd1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc();
      bus.MSR          = $urandom;
      bus.pipe_drained = ($urandom_range(0, 9) < 7);
      rst              = ($urandom_range(0, 149) == 0);
      if (!lat_dsi && !m_dsi_ack && $urandom_range(0, 5) == 0)
        set_dsi($urandom, $urandom, 1'($urandom_range(0, 1)));
      if (!lat_isi && !m_isi_ack && $urandom_range(0, 5) == 0)
        set_isi($urandom);
    end
    rst = 1'b0;
    bus.pipe_drained = 1'b1;
    wait_idle(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
